// File: rtl/matrix_index_counter.sv
// Two-level (row, column) index counter that walks a matrix of run-time
// configurable size in row-major or column-major order.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   clear        synchronous clear of both indices (highest priority)
//   load_limits  capture row_count/col_count/col_major and zero the indices
//   row_count    requested number of rows (0 -> 1, above MAX_ROWS -> MAX_ROWS)
//   col_count    requested number of columns (0 -> 1, above MAX_COLS -> MAX_COLS)
//   col_major    traversal order: 0 = columns inner, 1 = rows inner
//   increment    advance one element
//   row_index    current row (registered)
//   col_index    current column (registered)
//   last_row     row_index is the last legal row
//   last_col     col_index is the last legal column
//   last_value   last_row & last_col
//   wrap         one-cycle registered pulse after the traversal completes
module matrix_index_counter #(
  parameter int unsigned ROW_W    = 2,
  parameter int unsigned COL_W    = 2,
  parameter int unsigned MAX_ROWS = 3,
  parameter int unsigned MAX_COLS = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load_limits,
  input  logic [ROW_W-1:0] row_count,
  input  logic [COL_W-1:0] col_count,
  input  logic             col_major,
  input  logic             increment,
  output logic [ROW_W-1:0] row_index,
  output logic [COL_W-1:0] col_index,
  output logic             last_row,
  output logic             last_col,
  output logic             last_value,
  output logic             wrap
);

  // Elaboration-time legality checks on the parameters.
  if (MAX_ROWS < 1 || MAX_ROWS > (1 << ROW_W)) begin : g_bad_max_rows
    $error("matrix_index_counter: MAX_ROWS must be in 1..2**ROW_W");
  end
  if (MAX_COLS < 1 || MAX_COLS > (1 << COL_W)) begin : g_bad_max_cols
    $error("matrix_index_counter: MAX_COLS must be in 1..2**COL_W");
  end

  // Limits are one bit wider than the indices so that a full 2**W count fits.
  localparam logic [ROW_W:0] MaxRowsL = MAX_ROWS[ROW_W:0];
  localparam logic [COL_W:0] MaxColsL = MAX_COLS[COL_W:0];
  localparam logic [ROW_W:0] OneRowL  = (ROW_W+1)'(1);
  localparam logic [COL_W:0] OneColL  = (COL_W+1)'(1);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W:0]   row_lim_q, row_lim_d;
  logic [COL_W:0]   col_lim_q, col_lim_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;

  logic [ROW_W:0]   row_cnt_ext, row_lim_new;
  logic [COL_W:0]   col_cnt_ext, col_lim_new;
  logic [ROW_W:0]   row_last_idx;
  logic [COL_W:0]   col_last_idx;

  // Flags depend only on registered state.
  always_comb begin
    row_last_idx = row_lim_q - OneRowL;
    col_last_idx = col_lim_q - OneColL;
    last_row     = ({1'b0, row_q} == row_last_idx);
    last_col     = ({1'b0, col_q} == col_last_idx);
    last_value   = last_row & last_col;
  end

  // Sanitise requested counts into the legal range 1..MAX.
  always_comb begin
    row_cnt_ext = {1'b0, row_count};
    col_cnt_ext = {1'b0, col_count};
    if (row_cnt_ext == '0) begin
      row_lim_new = OneRowL;
    end else if (row_cnt_ext > MaxRowsL) begin
      row_lim_new = MaxRowsL;
    end else begin
      row_lim_new = row_cnt_ext;
    end
    if (col_cnt_ext == '0) begin
      col_lim_new = OneColL;
    end else if (col_cnt_ext > MaxColsL) begin
      col_lim_new = MaxColsL;
    end else begin
      col_lim_new = col_cnt_ext;
    end
  end

  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    row_lim_d = row_lim_q;
    col_lim_d = col_lim_q;
    mode_d    = mode_q;
    wrap_d    = 1'b0;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (load_limits) begin
      row_d     = '0;
      col_d     = '0;
      row_lim_d = row_lim_new;
      col_lim_d = col_lim_new;
      mode_d    = col_major;
    end else if (increment) begin
      if (!mode_q) begin
        // Row-major: columns are the inner dimension.
        if (!last_col) begin
          col_d = col_q + COL_W'(1);
        end else begin
          col_d = '0;
          if (!last_row) begin
            row_d = row_q + ROW_W'(1);
          end else begin
            row_d  = '0;
            wrap_d = 1'b1;
          end
        end
      end else begin
        // Column-major: rows are the inner dimension.
        if (!last_row) begin
          row_d = row_q + ROW_W'(1);
        end else begin
          row_d = '0;
          if (!last_col) begin
            col_d = col_q + COL_W'(1);
          end else begin
            col_d  = '0;
            wrap_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_q     <= '0;
      col_q     <= '0;
      row_lim_q <= MaxRowsL;
      col_lim_q <= MaxColsL;
      mode_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      row_lim_q <= row_lim_d;
      col_lim_q <= col_lim_d;
      mode_q    <= mode_d;
      wrap_q    <= wrap_d;
    end
  end

  assign row_index = row_q;
  assign col_index = col_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_matrix_index_counter.sv
module tb_matrix_index_counter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       load_limits;
  logic [1:0] row_count;
  logic [1:0] col_count;
  logic       col_major;
  logic       increment;
  logic [1:0] row_index;
  logic [1:0] col_index;
  logic       last_row;
  logic       last_col;
  logic       last_value;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  matrix_index_counter #(
    .ROW_W   (2),
    .COL_W   (2),
    .MAX_ROWS(3),
    .MAX_COLS(3)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (clear),
    .load_limits(load_limits),
    .row_count  (row_count),
    .col_count  (col_count),
    .col_major  (col_major),
    .increment  (increment),
    .row_index  (row_index),
    .col_index  (col_index),
    .last_row   (last_row),
    .last_col   (last_col),
    .last_value (last_value),
    .wrap       (wrap)
  );

  typedef struct {
    string      name;
    logic       clr;
    logic       ld;
    logic [1:0] rc;
    logic [1:0] cc;
    logic       cm;
    logic       inc;
    logic [1:0] er;
    logic [1:0] ec;
    logic       elr;
    logic       elc;
    logic       elv;
    logic       ew;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic clr, logic ld, logic [1:0] rc, logic [1:0] cc,
                              logic cm, logic inc, logic [1:0] er, logic [1:0] ec,
                              logic elr, logic elc, logic elv, logic ew);
    vec_t v;
    v.name = nm; v.clr = clr; v.ld = ld; v.rc = rc; v.cc = cc; v.cm = cm; v.inc = inc;
    v.er = er; v.ec = ec; v.elr = elr; v.elc = elc; v.elv = elv; v.ew = ew;
    return v;
  endfunction

  // Packed view {row, col, last_row, last_col, last_value, wrap}.
  task automatic check(string nm, logic [1:0] er, logic [1:0] ec, logic elr, logic elc,
                       logic elv, logic ew);
    logic [7:0] got;
    logic [7:0] exp;
    got = {row_index, col_index, last_row, last_col, last_value, wrap};
    exp = {er, ec, elr, elc, elv, ew};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got r=%0d c=%0d lr=%b lc=%b lv=%b w=%b, want r=%0d c=%0d lr=%b lc=%b lv=%b w=%b",
               nm, got[7:6], got[5:4], got[3], got[2], got[1], got[0],
               exp[7:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one cycle of inputs, then compare the state after the clock edge.
  task automatic apply(vec_t v);
    @(negedge clock);
    clear       = v.clr;
    load_limits = v.ld;
    row_count   = v.rc;
    col_count   = v.cc;
    col_major   = v.cm;
    increment   = v.inc;
    @(posedge clock);
    #1;
    check(v.name, v.er, v.ec, v.elr, v.elc, v.elv, v.ew);
  endtask

  initial begin
    reset_n     = 1'b0;
    clear       = 1'b0;
    load_limits = 1'b0;
    row_count   = '0;
    col_count   = '0;
    col_major   = 1'b0;
    increment   = 1'b0;

    // Default 3x3 row-major walk.
    vecs.push_back(mk("rm_inc1", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rm_inc2", 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk("rm_inc3", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rm_inc4", 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("rm_inc5", 0, 0, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0));
    vecs.push_back(mk("rm_inc6", 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0, 0));
    vecs.push_back(mk("rm_inc7", 0, 0, 0, 0, 0, 1, 2, 1, 1, 0, 0, 0));
    vecs.push_back(mk("rm_inc8", 0, 0, 0, 0, 0, 1, 2, 2, 1, 1, 1, 0));
    vecs.push_back(mk("rm_wrap", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk("rm_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // 2x3 column-major walk.
    vecs.push_back(mk("cm_load", 0, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("cm_inc1", 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk("cm_inc2", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("cm_inc3", 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0));
    vecs.push_back(mk("cm_inc4", 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk("cm_inc5", 0, 0, 0, 0, 0, 1, 1, 2, 1, 1, 1, 0));
    vecs.push_back(mk("cm_wrap", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    // Zero row count is stored as one row.
    vecs.push_back(mk("z_load",  0, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("z_inc1",  0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk("z_inc2",  0, 0, 0, 0, 0, 1, 0, 2, 1, 1, 1, 0));
    vecs.push_back(mk("z_wrap",  0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
    // 1x1 matrix: every increment wraps, wrap high on consecutive cycles.
    vecs.push_back(mk("one_load", 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    vecs.push_back(mk("one_w1",   0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk("one_w2",   0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, 1));
    vecs.push_back(mk("one_idle", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    // Clear beats increment at (1,2) of a 3x3.
    vecs.push_back(mk("cl_load", 0, 1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("cl_inc1", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("cl_inc2", 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0));
    vecs.push_back(mk("cl_inc3", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("cl_inc4", 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk("cl_inc5", 0, 0, 0, 0, 0, 1, 1, 2, 0, 1, 0, 0));
    vecs.push_back(mk("cl_clr",  1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("cl_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    #2;
    check("reset_state", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Walk to (2,2) of the 3x3, then load new limits together with increment.
    for (int i = 0; i < 8; i++) begin
      apply(mk("walk", 0, 0, 0, 0, 0, 1, 2'(((i + 1) / 3)), 2'(((i + 1) % 3)),
               (i + 1) >= 6, ((i + 1) % 3) == 2, (i + 1) == 8, 0));
    end
    apply(mk("ld_inc",    0, 1, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0));
    apply(mk("ld_inc_nw", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("ld2_inc1",  0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    apply(mk("ld2_inc2",  0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    apply(mk("ld2_inc3",  0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0));
    // Clear with a wrapping increment suppresses wrap.
    apply(mk("clr_wrap",  1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk("clr_nw",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(mk("ret_inc1",  0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    apply(mk("ret_inc2",  0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    apply(mk("ret_inc3",  0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0));

    // Asynchronous reset mid-cycle at (1,1).
    @(negedge clock);
    increment = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
    // Limits back to 3x3 row-major.
    apply(mk("post_rst1", 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    apply(mk("post_rst2", 0, 0, 0, 0, 0, 1, 0, 2, 0, 1, 0, 0));
    apply(mk("post_rst3", 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
